// File: rtl/proj_minhash_sketcher_if.sv
// Nucleotide input stream and signature output stream of the MinHash sketcher.
// The sketcher is the slave of both streams; the sequence reader and signature store form the master side.
interface proj_minhash_sketcher_if #(
    parameter int DATA_BITS = 2,
    parameter int HASH_BITS = 32,
    parameter int NUM_HASH  = 4,
    parameter int CNT_BITS  = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_BITS-1:0]          in_data;
    logic                          in_last;
    logic                          sig_valid;
    logic                          sig_ready;
    logic [NUM_HASH*HASH_BITS-1:0] sig_data;
    logic [CNT_BITS-1:0]           sig_kmer_count;

    modport master (
        output in_valid, in_data, in_last, sig_ready,
        input  in_ready, sig_valid, sig_data, sig_kmer_count
    );

    modport slave (
        input  in_valid, in_data, in_last, sig_ready,
        output in_ready, sig_valid, sig_data, sig_kmer_count
    );
endinterface

// File: rtl/proj_minhash_sketcher.sv
// Streaming MinHash sketcher: rolling k-mer window, NUM_HASH seeded hash lanes, running per-lane minimum.
// Optional canonical k-mers (min of forward and reverse complement) under `define PROJ_MINHASH_CANON_EN.
module proj_minhash_sketcher #(
    parameter int DATA_BITS = 2,
    parameter int KMER_LEN  = 16,
    parameter int HASH_BITS = 32,
    parameter int NUM_HASH  = 4,
    parameter int CNT_BITS  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_over,
    input  logic [NUM_HASH*HASH_BITS-1:0] seeds,
    output logic                          busy,
    proj_minhash_sketcher_if.slave        bus
);
    localparam int KW = KMER_LEN * DATA_BITS;
    localparam int FW = $clog2(KMER_LEN + 1);
    localparam logic [31:0] MUL_C1 = 32'h1b873593;
    localparam logic [31:0] ADD_C2 = 32'he6546b64;

    typedef enum logic [1:0] {S_FILL, S_DRAIN, S_OUT} state_e;

    state_e                             state_q, state_d;
    logic [1:0]                         drain_q, drain_d;
    logic                               accept, sig_done, clear;
    logic [KW-1:0]                      win_q;
    logic [FW-1:0]                      fill_q;
    logic                               seed_arm_q;
    logic [NUM_HASH-1:0][HASH_BITS-1:0] seed_q, s1_d, s1_q, h_q, min_q;
    logic                               v0_q, v1_q, v2_q;
    logic [CNT_BITS-1:0]                cnt_q;
    logic [HASH_BITS-1:0]               kmer, kmer_mix;

    function automatic logic [31:0] rol13(input logic [31:0] x);
        return {x[18:0], x[31:19]};
    endfunction

    function automatic logic [31:0] rol15(input logic [31:0] x);
        return {x[16:0], x[31:17]};
    endfunction

    // start_over outranks everything, including a beat offered in the same cycle
    assign accept   = bus.in_valid && (state_q == S_FILL) && !start_over;
    assign sig_done = (state_q == S_OUT) && bus.sig_ready;
    assign clear    = start_over || sig_done;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        bus.in_ready  = 1'b0;
        bus.sig_valid = 1'b0;
        case (state_q)
            S_FILL: begin
                bus.in_ready = 1'b1;
                drain_d      = 2'd0;
                if (accept && bus.in_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd3) state_d = S_OUT;
            end
            S_OUT: begin
                bus.sig_valid = 1'b1;
                if (bus.sig_ready) state_d = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
        if (start_over) begin
            state_d = S_FILL;
            drain_d = 2'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

`ifdef PROJ_MINHASH_CANON_EN
    logic [KW-1:0] rc_q;

    // Complement enters at the top so the register reads as the reverse complement of the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_q <= '0;
        end else if (clear) begin
            rc_q <= '0;
        end else if (accept) begin
            rc_q <= {~bus.in_data, rc_q[KW-1:DATA_BITS]};
        end
    end

    assign kmer = HASH_BITS'((rc_q < win_q) ? rc_q : win_q);
`else
    assign kmer = HASH_BITS'(win_q);
`endif

    assign kmer_mix = rol15(kmer) * MUL_C1;

    always_comb begin
        for (int i = 0; i < NUM_HASH; i++) begin
            s1_d[i] = rol13(seed_q[i]) ^ kmer_mix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= '0;
            fill_q     <= '0;
            seed_arm_q <= 1'b1;
            seed_q     <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            cnt_q      <= '0;
            min_q      <= '1;
        end else if (clear) begin
            win_q      <= '0;
            fill_q     <= '0;
            seed_arm_q <= 1'b1;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            cnt_q      <= '0;
            min_q      <= '1;
        end else begin
            if (accept) begin
                win_q <= {win_q[KW-DATA_BITS-1:0], bus.in_data};
                if (fill_q != FW'(KMER_LEN)) fill_q <= fill_q + 1'b1;
                if (seed_arm_q) begin
                    seed_q     <= seeds;
                    seed_arm_q <= 1'b0;
                end
            end
            v0_q <= accept && (fill_q >= FW'(KMER_LEN - 1));
            v1_q <= v0_q;
            v2_q <= v1_q;
            if (v2_q) begin
                for (int i = 0; i < NUM_HASH; i++) begin
                    if (h_q[i] < min_q[i]) min_q[i] <= h_q[i];
                end
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // NOTE: pure datapath flops carry no reset; the v*_q valid bits decide when their contents matter.
    always_ff @(posedge clk) begin
        s1_q <= s1_d;
        for (int i = 0; i < NUM_HASH; i++) begin
            h_q[i] <= s1_q[i] * 32'd5 + ADD_C2;
        end
    end

    assign bus.sig_data       = min_q;
    assign bus.sig_kmer_count = cnt_q;
    assign busy = (state_q != S_FILL) || (fill_q != '0) || v0_q || v1_q || v2_q;
endmodule

// File: tb/tb_proj_minhash_sketcher.sv
// Directed bench for proj_minhash_sketcher: a KMER_LEN=16 instance for the main flow and a KMER_LEN=4 instance for short and canonical cases.
module tb_proj_minhash_sketcher;
    localparam int NH = 4;
    localparam int HB = 32;
    localparam int CB = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_over = 1'b0;
    logic             start_over4 = 1'b0;
    logic [NH*HB-1:0] seeds = '0;
    logic [NH*HB-1:0] seeds4 = '0;
    logic             busy, busy4;

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  seq_mem [0:31];
    logic [31:0] seed_ref [0:3];
    logic [31:0] exp_min [0:3];
    logic [31:0] prev_min [0:3];
    int          exp_cnt;

    proj_minhash_sketcher_if #(.DATA_BITS(2), .HASH_BITS(HB), .NUM_HASH(NH), .CNT_BITS(CB)) bus16 ();
    proj_minhash_sketcher_if #(.DATA_BITS(2), .HASH_BITS(HB), .NUM_HASH(NH), .CNT_BITS(CB)) bus4 ();

    proj_minhash_sketcher #(.DATA_BITS(2), .KMER_LEN(16), .HASH_BITS(HB), .NUM_HASH(NH), .CNT_BITS(CB)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_over(start_over), .seeds(seeds), .busy(busy), .bus(bus16)
    );

    proj_minhash_sketcher #(.DATA_BITS(2), .KMER_LEN(4), .HASH_BITS(HB), .NUM_HASH(NH), .CNT_BITS(CB)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_over(start_over4), .seeds(seeds4), .busy(busy4), .bus(bus4)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] ref_hash(input logic [31:0] kmer, input logic [31:0] seed);
        logic [31:0] k, r;
        k = ((kmer << 15) | (kmer >> 17)) * 32'h1b873593;
        r = (seed << 13) | (seed >> 19);
        return ((r ^ k) * 32'd5) + 32'he6546b64;
    endfunction

    task automatic run_model(input int klen, input int len);
        logic [31:0] fwd, rc, hv;
        for (int l = 0; l < 4; l++) exp_min[l] = 32'hffffffff;
        exp_cnt = 0;
        for (int j = klen - 1; j < len; j++) begin
            fwd = '0;
            rc  = '0;
            for (int m = 0; m < klen; m++) begin
                fwd = (fwd << 2) | {30'd0, seq_mem[j-klen+1+m]};
                rc  = (rc << 2) | {30'd0, ~seq_mem[j-m]};
            end
`ifdef PROJ_MINHASH_CANON_EN
            if (rc < fwd) fwd = rc;
`endif
            exp_cnt++;
            for (int l = 0; l < 4; l++) begin
                hv = ref_hash(fwd, seed_ref[l]);
                if (hv < exp_min[l]) exp_min[l] = hv;
            end
        end
    endtask

    task automatic send16(input int n, input bit last, input bit gaps, input bit scramble);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            bus16.in_valid = 1'b1;
            bus16.in_data  = seq_mem[i];
            bus16.in_last  = last && (i == n - 1);
            checks++;
            if (bus16.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL send16_in_ready beat %0d: got %b expected 1", i, bus16.in_ready);
            end
            @(posedge clk); #1;
            bus16.in_valid = 1'b0;
            bus16.in_last  = 1'b0;
            if (scramble && i == 0) seeds = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic send4(input int n);
        for (int i = 0; i < n; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = seq_mem[i];
            bus4.in_last  = (i == n - 1);
            @(posedge clk); #1;
            bus4.in_valid = 1'b0;
            bus4.in_last  = 1'b0;
        end
    endtask

    task automatic wait_sig16(output int lat);
        lat = 0;
        while (bus16.sig_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_sig4(output int lat);
        lat = 0;
        while (bus4.sig_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack16();
        bus16.sig_ready = 1'b1;
        @(posedge clk); #1;
        bus16.sig_ready = 1'b0;
    endtask

    task automatic ack4();
        bus4.sig_ready = 1'b1;
        @(posedge clk); #1;
        bus4.sig_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bus16.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus16.in_ready);
        end
        checks++;
        if (bus16.sig_valid !== 1'b0) begin
            errors++; $display("FAIL reset_sig_valid: got %b expected 0", bus16.sig_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (bus16.sig_data !== {NH*HB{1'b1}}) begin
            errors++; $display("FAIL reset_sig_data: got %h expected all ones", bus16.sig_data);
        end
        checks++;
        if (bus16.sig_kmer_count !== 16'd0) begin
            errors++; $display("FAIL reset_kmer_count: got %0d expected 0", bus16.sig_kmer_count);
        end
    endtask

    // 16 x A with seeds 1..4: the k-mer is zero, so each lane is (ROL13(seed))*5 + 0xe6546b64
    task automatic test_poly_a();
        logic [31:0] poly_exp [0:3];
        int lat;
        poly_exp[0] = 32'he6550b64;
        poly_exp[1] = 32'he655ab64;
        poly_exp[2] = 32'he6564b64;
        poly_exp[3] = 32'he656eb64;
        seeds = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int i = 0; i < 16; i++) seq_mem[i] = 2'd0;
        send16(16, 1'b1, 1'b0, 1'b0);
        wait_sig16(lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL poly_a_latency: got %0d expected 4", lat);
        end
        checks++;
        if (bus16.sig_kmer_count !== 16'd1) begin
            errors++; $display("FAIL poly_a_kmer_count: got %0d expected 1", bus16.sig_kmer_count);
        end
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (bus16.sig_data[l*32 +: 32] !== poly_exp[l]) begin
                errors++;
                $display("FAIL poly_a_lane%0d: got %h expected %h", l, bus16.sig_data[l*32 +: 32], poly_exp[l]);
            end
        end
        start_over = 1'b1;
        @(posedge clk); #1;
        start_over = 1'b0;
        checks++;
        if (bus16.sig_valid !== 1'b0 || bus16.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL poly_a_abort_in_out: got valid=%b ready=%b busy=%b expected 0 1 0",
                     bus16.sig_valid, bus16.in_ready, busy);
        end
        checks++;
        if (bus16.sig_data !== {NH*HB{1'b1}}) begin
            errors++; $display("FAIL poly_a_abort_sig_data: got %h expected all ones", bus16.sig_data);
        end
    endtask

    task automatic test_random20();
        int lat;
        seeds = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int i = 0; i < 20; i++) seq_mem[i] = 2'($urandom_range(0, 3));
        run_model(16, 20);
        send16(20, 1'b1, 1'b1, 1'b1);
        wait_sig16(lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL rand20_latency: got %0d expected 4", lat);
        end
        checks++;
        if (bus16.sig_kmer_count !== 16'd5) begin
            errors++; $display("FAIL rand20_kmer_count: got %0d expected 5", bus16.sig_kmer_count);
        end
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (bus16.sig_data[l*32 +: 32] !== exp_min[l]) begin
                errors++;
                $display("FAIL rand20_lane%0d: got %h expected %h", l, bus16.sig_data[l*32 +: 32], exp_min[l]);
            end
        end
    endtask

    // Signature from test_random20 is pending; inputs keep toggling while sig_ready stays low
    task automatic test_hold();
        int lat;
        bus16.in_valid  = 1'b1;
        bus16.in_last   = 1'b1;
        bus16.sig_ready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            bus16.in_data = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            checks++;
            if (bus16.sig_valid !== 1'b1 || bus16.in_ready !== 1'b0 ||
                bus16.sig_data !== {exp_min[3], exp_min[2], exp_min[1], exp_min[0]} ||
                bus16.sig_kmer_count !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b data=%h cnt=%0d expected 1 0 %h %0d",
                         c, bus16.sig_valid, bus16.in_ready, bus16.sig_data, bus16.sig_kmer_count,
                         {exp_min[3], exp_min[2], exp_min[1], exp_min[0]}, exp_cnt);
            end
        end
        ack16();
        checks++;
        if (bus16.in_ready !== 1'b1 || bus16.sig_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_ack: got ready=%b valid=%b busy=%b expected 1 0 0",
                     bus16.in_ready, bus16.sig_valid, busy);
        end
        checks++;
        if (bus16.sig_data !== {NH*HB{1'b1}} || bus16.sig_kmer_count !== 16'd0) begin
            errors++;
            $display("FAIL hold_after_ack_clear: got data=%h cnt=%0d expected all ones 0",
                     bus16.sig_data, bus16.sig_kmer_count);
        end
        // in_valid/in_last are still high: a single-nucleotide sequence is accepted this cycle
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        bus16.in_last  = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus16.in_ready !== 1'b0) begin
            errors++; $display("FAIL single_nt_accept: got busy=%b ready=%b expected 1 0", busy, bus16.in_ready);
        end
        wait_sig16(lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL single_nt_latency: got %0d expected 4", lat);
        end
        checks++;
        if (bus16.sig_kmer_count !== 16'd0 || bus16.sig_data !== {NH*HB{1'b1}}) begin
            errors++;
            $display("FAIL single_nt_sig: got cnt=%0d data=%h expected 0 all ones",
                     bus16.sig_kmer_count, bus16.sig_data);
        end
        ack16();
    endtask

    task automatic test_start_over();
        int lat;
        seeds = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int i = 0; i < 20; i++) seq_mem[i] = 2'($urandom_range(0, 3));
        send16(10, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL abort_busy_before: got %b expected 1", busy);
        end
        start_over     = 1'b1;
        bus16.in_valid = 1'b1;
        bus16.in_data  = 2'd2;
        bus16.in_last  = 1'b1;
        @(posedge clk); #1;
        start_over     = 1'b0;
        bus16.in_valid = 1'b0;
        bus16.in_last  = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus16.in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_cleared: got busy=%b ready=%b expected 0 1", busy, bus16.in_ready);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus16.sig_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_beat_ignored: got valid=%b busy=%b expected 0 0", bus16.sig_valid, busy);
        end
        for (int i = 0; i < 17; i++) seq_mem[i] = 2'($urandom_range(0, 3));
        run_model(16, 17);
        send16(17, 1'b1, 1'b1, 1'b0);
        wait_sig16(lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL seq17_latency: got %0d expected 4", lat);
        end
        checks++;
        if (bus16.sig_kmer_count !== 16'd2) begin
            errors++; $display("FAIL seq17_kmer_count: got %0d expected 2", bus16.sig_kmer_count);
        end
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (bus16.sig_data[l*32 +: 32] !== exp_min[l]) begin
                errors++;
                $display("FAIL seq17_lane%0d: got %h expected %h", l, bus16.sig_data[l*32 +: 32], exp_min[l]);
            end
        end
        ack16();
    endtask

    task automatic test_kmer4();
        int lat;
        seeds4 = {32'd4, 32'd3, 32'd2, 32'd1};
        // ACG: shorter than one k-mer
        seq_mem[0] = 2'd0; seq_mem[1] = 2'd1; seq_mem[2] = 2'd2;
        send4(3);
        wait_sig4(lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL short_latency: got %0d expected 4", lat);
        end
        checks++;
        if (bus4.sig_kmer_count !== 16'd0 || bus4.sig_data !== {NH*HB{1'b1}}) begin
            errors++;
            $display("FAIL short_sig: got cnt=%0d data=%h expected 0 all ones", bus4.sig_kmer_count, bus4.sig_data);
        end
        ack4();
        // AACG
        seq_mem[0] = 2'd0; seq_mem[1] = 2'd0; seq_mem[2] = 2'd1; seq_mem[3] = 2'd2;
        run_model(4, 4);
        for (int l = 0; l < 4; l++) prev_min[l] = exp_min[l];
        send4(4);
        wait_sig4(lat);
        checks++;
        if (bus4.sig_kmer_count !== 16'd1) begin
            errors++; $display("FAIL aacg_kmer_count: got %0d expected 1", bus4.sig_kmer_count);
        end
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (bus4.sig_data[l*32 +: 32] !== exp_min[l]) begin
                errors++;
                $display("FAIL aacg_lane%0d: got %h expected %h", l, bus4.sig_data[l*32 +: 32], exp_min[l]);
            end
        end
        ack4();
        // CGTT, the reverse complement of AACG
        seq_mem[0] = 2'd1; seq_mem[1] = 2'd2; seq_mem[2] = 2'd3; seq_mem[3] = 2'd3;
        run_model(4, 4);
        send4(4);
        wait_sig4(lat);
        checks++;
        if (bus4.sig_kmer_count !== 16'd1) begin
            errors++; $display("FAIL cgtt_kmer_count: got %0d expected 1", bus4.sig_kmer_count);
        end
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (bus4.sig_data[l*32 +: 32] !== exp_min[l]) begin
                errors++;
                $display("FAIL cgtt_lane%0d: got %h expected %h", l, bus4.sig_data[l*32 +: 32], exp_min[l]);
            end
`ifdef PROJ_MINHASH_CANON_EN
            checks++;
            if (bus4.sig_data[l*32 +: 32] !== prev_min[l]) begin
                errors++;
                $display("FAIL canon_equal_lane%0d: got %h expected %h", l, bus4.sig_data[l*32 +: 32], prev_min[l]);
            end
`endif
        end
        ack4();
    endtask

    task automatic test_reset_mid();
        seeds = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int i = 0; i < 5; i++) seq_mem[i] = 2'd3;
        send16(5, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.sig_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b ready=%b valid=%b expected 0 1 0",
                     busy, bus16.in_ready, bus16.sig_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || bus16.sig_kmer_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_after: got busy=%b cnt=%0d expected 0 0", busy, bus16.sig_kmer_count);
        end
    endtask

    initial begin
        bus16.in_valid = 1'b0; bus16.in_data = 2'd0; bus16.in_last = 1'b0; bus16.sig_ready = 1'b0;
        bus4.in_valid  = 1'b0; bus4.in_data  = 2'd0; bus4.in_last  = 1'b0; bus4.sig_ready  = 1'b0;
        for (int l = 0; l < 4; l++) seed_ref[l] = 32'(l + 1);
        test_reset();
        test_poly_a();
        test_random20();
        test_hold();
        test_start_over();
        test_kmer4();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
